// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core (IF/ID/EX/MEM/WB) on synchronous-read memories; MCPU_PERF_CNT_EN adds perf counters.
// Latency: 3 cycles branch/J/NOP, 4 cycles ALU/SW, 5 cycles LW; inst_done pulses in the final cycle.
// Backpressure: none; both memories have a fixed one-cycle read latency, so the core never stalls.
module multi_cycle_cpu #(
    parameter logic [31:0] START_ADDR = 32'd0,
    parameter int          IMEM_AW    = 5,
    parameter int          DMEM_AW    = 5
) (
    input  logic               clk,
    input  logic               resetn,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [3:0]         dmem_wen,
    output logic [31:0]        dmem_wdata,
    input  logic [31:0]        dmem_rdata,
    input  logic [4:0]         rf_addr,
    output logic [31:0]        rf_data,
    output logic [31:0]        cpu_pc,
    output logic [31:0]        cpu_inst,
    output logic [2:0]         cpu_state,
    output logic               inst_done,
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        retire_cnt
);
    typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                           OP_ADDIU = 6'h09, OP_ANDI = 6'h0C, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx, ir, a_reg, b_reg, aluout, alu_res;
    logic [31:0] regs [32];
    logic        pc_we, done_c, rf_we_c, dmem_we_c, r_ok, writes_reg;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, sa, wb_addr;
    logic [15:0] imm;
    logic [31:0] imm_sext, imm_zext, pc_plus4, br_target, j_target, wb_val;
    logic [4:0]  id_rs, id_rt;

    assign op       = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign sa       = ir[10:6];
    assign funct    = ir[5:0];
    assign imm      = ir[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0, imm};
    assign pc_plus4 = pc + 32'd4;
    assign br_target = pc + {{14{imm[15]}}, imm, 2'b00};
    assign j_target  = {pc[31:28], ir[25:0], 2'b00};

    // Register-file sources are picked from the memory word itself, before IR is loaded.
    assign id_rs = imem_rdata[25:21];
    assign id_rt = imem_rdata[20:16];

    always_comb begin
        alu_res = 32'd0;
        r_ok    = 1'b0;
        if (op == OP_RTYPE) begin
            r_ok = 1'b1;
            case (funct)
                6'h21:   alu_res = a_reg + b_reg;
                6'h23:   alu_res = a_reg - b_reg;
                6'h2A:   alu_res = {31'd0, $signed(a_reg) < $signed(b_reg)};
                6'h2B:   alu_res = {31'd0, a_reg < b_reg};
                6'h24:   alu_res = a_reg & b_reg;
                6'h25:   alu_res = a_reg | b_reg;
                6'h27:   alu_res = ~(a_reg | b_reg);
                6'h26:   alu_res = a_reg ^ b_reg;
                6'h00:   alu_res = b_reg << sa;
                6'h02:   alu_res = b_reg >> sa;
                6'h03:   alu_res = $unsigned($signed(b_reg) >>> sa);
                default: r_ok = 1'b0;
            endcase
        end else begin
            case (op)
                OP_ADDIU, OP_LW, OP_SW: alu_res = a_reg + imm_sext;
                OP_ANDI:                alu_res = a_reg & imm_zext;
                OP_LUI:                 alu_res = {imm, 16'h0};
                default:                alu_res = 32'd0;
            endcase
        end
    end

    assign writes_reg = r_ok || op == OP_ADDIU || op == OP_ANDI || op == OP_LUI || op == OP_LW;
    assign wb_addr    = (op == OP_RTYPE) ? rd : rt;
    assign wb_val     = (op == OP_LW) ? dmem_rdata : aluout;

    always_comb begin
        state_nx  = state;
        pc_nx     = pc_plus4;
        pc_we     = 1'b0;
        done_c    = 1'b0;
        rf_we_c   = 1'b0;
        dmem_we_c = 1'b0;
        case (state)
            S_IF: state_nx = S_ID;
            S_ID: state_nx = S_EX;
            S_EX: begin
                if (op == OP_LW || op == OP_SW) begin
                    state_nx = S_MEM;
                end else if (writes_reg) begin
                    state_nx = S_WB;
                end else begin
                    state_nx = S_IF;
                    done_c   = 1'b1;
                    pc_we    = 1'b1;
                    if ((op == OP_BEQ && a_reg == b_reg) || (op == OP_BNE && a_reg != b_reg))
                        pc_nx = br_target;
                    else if (op == OP_J)
                        pc_nx = j_target;
                end
            end
            S_MEM: begin
                if (op == OP_SW) begin
                    dmem_we_c = 1'b1;
                    done_c    = 1'b1;
                    pc_we     = 1'b1;
                    state_nx  = S_IF;
                end else begin
                    state_nx  = S_WB;
                end
            end
            S_WB: begin
                rf_we_c  = wb_addr != 5'd0;
                done_c   = 1'b1;
                pc_we    = 1'b1;
                state_nx = S_IF;
            end
            default: state_nx = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= S_IF;
            pc     <= START_ADDR;
            ir     <= 32'd0;
            a_reg  <= 32'd0;
            b_reg  <= 32'd0;
            aluout <= 32'd0;
        end else begin
            state <= state_nx;
            if (state == S_ID) begin
                ir    <= imem_rdata;
                a_reg <= (id_rs == 5'd0) ? 32'd0 : regs[id_rs];
                b_reg <= (id_rt == 5'd0) ? 32'd0 : regs[id_rt];
            end
            if (state == S_EX)
                aluout <= alu_res;
            if (pc_we)
                pc <= pc_nx;
        end
    end

    // Write enables are gated by resetn so a reset in MEM/WB aborts the instruction cleanly.
    always_ff @(posedge clk) begin
        if (rf_we_c && resetn)
            regs[wb_addr] <= wb_val;
    end

    assign imem_addr  = pc[IMEM_AW+1:2];
    assign dmem_addr  = aluout[DMEM_AW+1:2];
    assign dmem_wdata = b_reg;
    assign dmem_wen   = {4{dmem_we_c & resetn}};
    assign inst_done  = done_c & resetn;
    assign rf_data    = (rf_addr == 5'd0) ? 32'd0 : regs[rf_addr];
    assign cpu_pc     = pc;
    assign cpu_inst   = ir;
    assign cpu_state  = state;

`ifdef MCPU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cycle_cnt  <= 32'd0;
            retire_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (inst_done)
                retire_cnt <= retire_cnt + 32'd1;
        end
    end
`else
    assign cycle_cnt  = 32'd0;
    assign retire_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Directed bench for multi_cycle_cpu: program-level scoreboard of per-instruction expectations,
// checked at each inst_done, plus reset, mid-SW reset and counter checks.
module tb_multi_cycle_cpu;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [4:0]  imem_addr, dmem_addr;
    logic [31:0] imem_rdata, dmem_rdata, dmem_wdata;
    logic [3:0]  dmem_wen;
    logic [4:0]  rf_addr = 5'd0;
    logic [31:0] rf_data, cpu_pc, cpu_inst, cycle_cnt, retire_cnt;
    logic [2:0]  cpu_state;
    logic        inst_done;

    logic [31:0] imem [32];
    logic [31:0] dmem [32] = '{default: 32'd0};

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        int          cycles;
        logic [31:0] npc;
        int          ridx;
        logic [31:0] rval;
        bit          sw;
        int          daddr;
        logic [31:0] wdata;
    } exp_t;
    exp_t sb[$];

    multi_cycle_cpu #(.START_ADDR(32'd0), .IMEM_AW(5), .DMEM_AW(5)) dut (
        .clk(clk), .resetn(resetn),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .rf_addr(rf_addr), .rf_data(rf_data),
        .cpu_pc(cpu_pc), .cpu_inst(cpu_inst), .cpu_state(cpu_state), .inst_done(inst_done),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        imem_rdata <= imem[imem_addr];
        dmem_rdata <= dmem[dmem_addr];
        if (dmem_wen == 4'hF)
            dmem[dmem_addr] <= dmem_wdata;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Place an instruction in memory and queue what its execution must look like.
    task automatic prog(input logic [31:0] pc, input logic [31:0] inst, input int cyc,
                        input logic [31:0] npc, input int ridx, input logic [31:0] rval,
                        input bit sw, input int daddr, input logic [31:0] wdata);
        exp_t e;
        imem[pc[6:2]] = inst;
        e.pc = pc; e.inst = inst; e.cycles = cyc; e.npc = npc; e.ridx = ridx; e.rval = rval;
        e.sw = sw; e.daddr = daddr; e.wdata = wdata;
        sb.push_back(e);
    endtask

    task automatic retire_one();
        exp_t e;
        int   n;
        e = sb.pop_front();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (inst_done !== 1'b1 && n < 12);
        check("done_seen", 32'(inst_done), 32'd1);
        check("cycles", 32'(n), 32'(e.cycles));
        check("pc", cpu_pc, e.pc);
        check("ir", cpu_inst, e.inst);
        if (e.sw) begin
            check("sw_wen", 32'(dmem_wen), 32'hF);
            check("sw_addr", 32'(dmem_addr), 32'(e.daddr));
            check("sw_wdata", dmem_wdata, e.wdata);
        end else begin
            check("wen_idle", 32'(dmem_wen), 32'd0);
        end
        @(posedge clk);
        #1;
        check("next_pc", cpu_pc, e.npc);
        check("wen_after", 32'(dmem_wen), 32'd0);
        check("state_if", 32'(cpu_state), 32'd0);
        rf_addr = e.ridx[4:0];
        #1;
        check("rf", rf_data, e.rval);
    endtask

    logic [31:0] exp_ret, exp_cyc;
    int          n;

    initial begin
        for (int i = 0; i < 32; i++) imem[i[4:0]] = 32'd0;

        // Reset held three cycles
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", cpu_pc, 32'd0);
        check("rst_state", 32'(cpu_state), 32'd0);
        check("rst_wen", 32'(dmem_wen), 32'd0);
        check("rst_done", 32'(inst_done), 32'd0);
        check("rst_ir", cpu_inst, 32'd0);
        check("rst_retire", retire_cnt, 32'd0);

        prog(32'h00, 32'h24010005, 4, 32'h04, 1, 32'h5,        1'b0, 0, 32'd0);
        prog(32'h04, 32'h00001027, 4, 32'h08, 2, 32'hFFFFFFFF, 1'b0, 0, 32'd0);
        prog(32'h08, 32'h24021234, 4, 32'h0C, 2, 32'h1234,     1'b0, 0, 32'd0);
        prog(32'h0C, 32'hAC020008, 4, 32'h10, 2, 32'h1234,     1'b1, 2, 32'h1234);
        prog(32'h10, 32'h1000FFFF, 3, 32'h0C, 2, 32'h1234,     1'b0, 0, 32'd0);
        resetn = 1'b1;
        while (sb.size() > 0) retire_one();
        check("dmem2", dmem[2], 32'h1234);

        // BEQ looped back; swap it for a BNE so the second pass falls through.
        prog(32'h0C, 32'hAC020008, 4, 32'h10, 2, 32'h1234,     1'b1, 2, 32'h1234);
        prog(32'h10, 32'h1400FFFF, 3, 32'h14, 2, 32'h1234,     1'b0, 0, 32'd0);
        prog(32'h14, 32'h8C030008, 5, 32'h18, 3, 32'h1234,     1'b0, 0, 32'd0);
        prog(32'h18, 32'h2401FFFF, 4, 32'h1C, 1, 32'hFFFFFFFF, 1'b0, 0, 32'd0);
        prog(32'h1C, 32'h30248000, 4, 32'h20, 4, 32'h00008000, 1'b0, 0, 32'd0);
        prog(32'h20, 32'h00012903, 4, 32'h24, 5, 32'hFFFFFFFF, 1'b0, 0, 32'd0);
        prog(32'h24, 32'hFC000000, 3, 32'h28, 0, 32'h0,        1'b0, 0, 32'd0);
        prog(32'h28, 32'h3C06ABCD, 4, 32'h2C, 6, 32'hABCD0000, 1'b0, 0, 32'd0);
        prog(32'h2C, 32'h0001382B, 4, 32'h30, 7, 32'h1,        1'b0, 0, 32'd0);
        prog(32'h30, 32'h0800000E, 3, 32'h38, 3, 32'h1234,     1'b0, 0, 32'd0);
        imem[13] = 32'h24080001;
        imem[14] = 32'hAC01000C;
        while (sb.size() > 0) retire_one();
        rf_addr = 5'd5;
        #1;
        check("illegal_no_write", rf_data, 32'hFFFFFFFF);

        // Reset while the SW at 0x38 sits in MEM
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cpu_state !== 3'd3 && n < 10);
        check("sw_mem_reached", 32'(cpu_state), 32'd3);
        resetn = 1'b0;
        #1;
        check("midrst_wen", 32'(dmem_wen), 32'd0);
        check("midrst_done", 32'(inst_done), 32'd0);
        @(posedge clk);
        #1;
        check("midrst_pc", cpu_pc, 32'd0);
        check("midrst_state", 32'(cpu_state), 32'd0);
        check("midrst_dmem3", dmem[3], 32'd0);

        for (int i = 0; i < 32; i++) imem[i[4:0]] = 32'd0;
        for (int i = 0; i < 10; i++)
            prog(32'(i * 4), 32'h24090000 | 32'(i + 1), 4, 32'(i * 4 + 4), 9, 32'(i + 1), 1'b0, 0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst2_cycle", cycle_cnt, 32'd0);
        resetn = 1'b1;
        while (sb.size() > 0) retire_one();
`ifdef MCPU_PERF_CNT_EN
        exp_ret = 32'd10;
        exp_cyc = 32'd40;
`else
        exp_ret = 32'd0;
        exp_cyc = 32'd0;
`endif
        check("retire_cnt", retire_cnt, exp_ret);
        check("cycle_cnt", cycle_cnt, exp_cyc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
